mem_arbiter: RTL and testbench

Shares one single-port synchronous memory between the RISC_V_lite instruction-fetch path and its data-access path. The two paths use separate request/grant/response handshakes. The arbiter serialises their accesses onto one memory port and gives data accesses priority. A starvation counter guarantees that fetch makes forward progress. It sits between RISC_V_lite and a unified Memory_interface-style storage model, replacing the split instruction/data memories in the system-level bench.

---
 rtl/riscv_mem_pkg.sv | 21 ++
 rtl/mem_arb_prio.sv | 41 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - Shared types and default widths for the fetch/data memory arbiter
package riscv_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Arbiter sequencing: one access in flight, read responses return through WAIT/RESP
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Which requester owns the access currently in flight
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - Data-priority winner select with fetch anti-starvation counter
module mem_arb_prio
  import riscv_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   arbitrate,
  output owner_t winner
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] SAT = SW'(MAX_WAIT);

  logic [SW-1:0] starve_cnt;

  // Data wins by default; fetch wins when it is alone or has lost MAX_WAIT times in a row
  always_comb begin
    winner = OWN_D;
    if (if_req && (!d_req || starve_cnt == SAT)) begin
      winner = OWN_IF;
    end
  end

  // Count consecutive fetch losses; any idle cycle without a fetch request forgets the history
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arbitrate) begin
      if (!if_req || winner == OWN_IF) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SAT) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Fetch/data arbiter onto one single-port synchronous memory
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_RVALID,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              MEM_CS,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LAT - 1);

  state_t            state, state_d;
  owner_t            owner, owner_d, win;
  logic [LW-1:0]     lat_cnt, lat_d;
  logic              arbitrate;
  logic              cs_d, we_d, if_gnt_d, d_gnt_d, if_rv_d, d_rv_d, busy_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, if_rdata_d, d_rdata_d;

  assign arbitrate = (state == IDLE);

  mem_arb_prio #(
    .MAX_WAIT(MAX_WAIT)
  ) u_prio (
    .clk      (CLOCK),
    .rst      (RESET),
    .if_req   (IF_REQ),
    .d_req    (D_REQ),
    .arbitrate(arbitrate),
    .winner   (win)
  );

  // Next state plus next value of every output register, so no input reaches an output combinationally
  always_comb begin
    state_d    = state;
    owner_d    = owner;
    lat_d      = lat_cnt;
    addr_d     = MEM_ADDR;
    we_d       = MEM_WE;
    wdata_d    = MEM_WDATA;
    if_rdata_d = IF_RDATA;
    d_rdata_d  = D_RDATA;
    cs_d       = 1'b0;
    if_gnt_d   = 1'b0;
    d_gnt_d    = 1'b0;
    if_rv_d    = 1'b0;
    d_rv_d     = 1'b0;
    case (state)
      IDLE: begin
        if (IF_REQ || D_REQ) begin
          owner_d = win;
          cs_d    = 1'b1;
          state_d = ISSUE;
          if (win == OWN_IF) begin
            addr_d   = IF_ADDR;
            we_d     = 1'b0;
            wdata_d  = '0;
            if_gnt_d = 1'b1;
          end else begin
            addr_d  = D_ADDR;
            we_d    = D_WE;
            wdata_d = D_WDATA;
            d_gnt_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (MEM_WE) begin
          state_d = IDLE;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          state_d = RESP;
          if (owner == OWN_IF) begin
            if_rdata_d = MEM_RDATA;
            if_rv_d    = 1'b1;
          end else begin
            d_rdata_d = MEM_RDATA;
            d_rv_d    = 1'b1;
          end
        end else begin
          lat_d = lat_cnt - LW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any in-flight read so its RVALID never appears
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      lat_cnt   <= '0;
      MEM_CS    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      IF_GNT    <= 1'b0;
      D_GNT     <= 1'b0;
      IF_RVALID <= 1'b0;
      D_RVALID  <= 1'b0;
      IF_RDATA  <= '0;
      D_RDATA   <= '0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      lat_cnt   <= lat_d;
      MEM_CS    <= cs_d;
      MEM_WE    <= we_d;
      MEM_ADDR  <= addr_d;
      MEM_WDATA <= wdata_d;
      IF_GNT    <= if_gnt_d;
      D_GNT     <= d_gnt_d;
      IF_RVALID <= if_rv_d;
      D_RVALID  <= d_rv_d;
      IF_RDATA  <= if_rdata_d;
      D_RDATA   <= d_rdata_d;
      BUSY      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int MW   = 4;
  localparam int RING = 16;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          IF_REQ;
  logic [AW-1:0] IF_ADDR;
  logic          IF_GNT, IF_RVALID;
  logic [DW-1:0] IF_RDATA;
  logic          D_REQ, D_WE;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          D_GNT, D_RVALID;
  logic [DW-1:0] D_RDATA;
  logic          MEM_CS, MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA, MEM_RDATA;
  logic          BUSY;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_WAIT(MW)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_RVALID(IF_RVALID), .IF_RDATA(IF_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [DW-1:0] init_word(int i);
    if (i == 4) return 32'h0000_0013;
    return 32'hA500_0000 | (32'(i) * 32'h0001_0101);
  endfunction

  // Unified storage: word-addressed, read data appears LAT cycles after the strobe cycle
  logic [DW-1:0] store [256];
  logic [DW-1:0] rpipe [LAT];
  logic          store_ready = 1'b0;
  always @(posedge CLOCK) begin
    if (!store_ready) begin
      for (int i = 0; i < 256; i++) store[i] <= init_word(i);
      for (int i = 0; i < LAT; i++) rpipe[i] <= '0;
      store_ready <= 1'b1;
    end else begin
      if (MEM_CS) begin
        if (MEM_WE) store[MEM_ADDR[9:2]] <= MEM_WDATA;
        rpipe[0] <= store[MEM_ADDR[9:2]];
      end
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
  end
  assign MEM_RDATA = rpipe[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, free_at, last_arb, starve;
  logic [DW-1:0] model_mem [256];
  bit            s_if_gnt [RING], s_d_gnt [RING], s_cs [RING], s_we [RING], s_if_rv [RING], s_d_rv [RING];
  logic [AW-1:0] s_addr [RING];
  logic [DW-1:0] s_wdata [RING], s_rdata [RING];
  logic [DW-1:0] m_if_rdata, m_d_rdata;
  bit            log_on = 1'b0;
  int            glog [$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void clear_slot(int k);
    s_if_gnt[k] = 0; s_d_gnt[k] = 0; s_cs[k] = 0; s_we[k] = 0;
    s_if_rv[k] = 0;  s_d_rv[k] = 0;  s_addr[k] = '0; s_wdata[k] = '0; s_rdata[k] = '0;
  endfunction

  // Schedule the whole transaction the moment it is arbitrated, from the inputs sampled this cycle
  task automatic model_step();
    int  k1, k2, idx;
    bit  fetch;
    if (RESET) begin
      for (int i = 0; i < RING; i++) clear_slot(i);
      free_at = cyc + 1; last_arb = cyc; starve = 0;
      m_if_rdata = '0; m_d_rdata = '0;
    end else if (cyc >= free_at) begin
      if (!IF_REQ) starve = 0;
      if (IF_REQ || D_REQ) begin
        fetch = IF_REQ && (!D_REQ || starve == MW);
        if (fetch) starve = 0;
        else if (IF_REQ && starve < MW) starve++;
        k1 = (cyc + 1) % RING;
        s_cs[k1]     = 1;
        s_if_gnt[k1] = fetch;
        s_d_gnt[k1]  = !fetch;
        s_we[k1]     = fetch ? 1'b0 : D_WE;
        s_addr[k1]   = fetch ? IF_ADDR : D_ADDR;
        s_wdata[k1]  = D_WDATA;
        idx          = int'(s_addr[k1][9:2]);
        last_arb     = cyc;
        if (s_we[k1]) begin
          model_mem[idx] = D_WDATA;
          free_at = cyc + 2;
        end else begin
          k2 = (cyc + 2 + LAT) % RING;
          s_if_rv[k2] = fetch;
          s_d_rv[k2]  = !fetch;
          s_rdata[k2] = model_mem[idx];
          free_at = cyc + 3 + LAT;
        end
      end
    end
  endtask

  task automatic check_cycle();
    int k;
    k = cyc % RING;
    if (s_if_rv[k]) m_if_rdata = s_rdata[k];
    if (s_d_rv[k])  m_d_rdata  = s_rdata[k];
    chk("if_gnt",    64'(IF_GNT),    64'(s_if_gnt[k]));
    chk("d_gnt",     64'(D_GNT),     64'(s_d_gnt[k]));
    chk("mem_cs",    64'(MEM_CS),    64'(s_cs[k]));
    if (s_cs[k]) begin
      chk("mem_we",   64'(MEM_WE),   64'(s_we[k]));
      chk("mem_addr", 64'(MEM_ADDR), 64'(s_addr[k]));
      if (s_we[k]) chk("mem_wdata", 64'(MEM_WDATA), 64'(s_wdata[k]));
    end
    chk("if_rvalid", 64'(IF_RVALID), 64'(s_if_rv[k]));
    chk("d_rvalid",  64'(D_RVALID),  64'(s_d_rv[k]));
    chk("if_rdata",  64'(IF_RDATA),  64'(m_if_rdata));
    chk("d_rdata",   64'(D_RDATA),   64'(m_d_rdata));
    chk("busy",      64'(BUSY),      64'((cyc > last_arb) && (cyc < free_at)));
    clear_slot(k);
  endtask

  // Inputs driven before a tick belong to the current cycle; outputs are checked mid next cycle
  task automatic tick();
    model_step();
    @(negedge CLOCK);
    cyc++;
    check_cycle();
    if (log_on) begin
      if (IF_GNT) glog.push_back(1);
      if (D_GNT)  glog.push_back(0);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  // Single fetch from 0x10 measured against hand-computed latencies
  task automatic fetch_0x10(string tag);
    int gnt_n, rv_n, cs_cnt;
    logic [DW-1:0] rv_data;
    gnt_n = -1; rv_n = -1; cs_cnt = 0; rv_data = '0;
    IF_REQ = 1; IF_ADDR = 32'h0000_0010;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (IF_GNT) begin gnt_n = n; IF_REQ = 0; end
      if (IF_RVALID) begin rv_n = n; rv_data = IF_RDATA; end
      if (MEM_CS) cs_cnt++;
    end
    IF_REQ = 0;
    chk({tag, "_gnt_lat"},   64'(gnt_n),   64'd1);
    chk({tag, "_rv_lat"},    64'(rv_n),    64'd5);
    chk({tag, "_rv_data"},   64'(rv_data), 64'h13);
    chk({tag, "_cs_cycles"}, 64'(cs_cnt),  64'd1);
  endtask

  initial begin
    int gnt_n, rv_n, rv_cnt;
    logic [DW-1:0] rv_data;

    RESET = 1; IF_REQ = 0; IF_ADDR = '0; D_REQ = 0; D_WE = 0; D_ADDR = '0; D_WDATA = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    for (int i = 0; i < RING; i++) clear_slot(i);
    m_if_rdata = '0; m_d_rdata = '0;
    cyc = 0; free_at = 0; last_arb = 0; starve = 0;
    repeat (3) tick();
    RESET = 0;
    repeat (2) tick();
    chk("rst_busy",     64'(BUSY),          64'd0);
    chk("rst_gnts",     64'(IF_GNT | D_GNT), 64'd0);
    chk("rst_mem_cs",   64'(MEM_CS),        64'd0);
    chk("rst_if_rdata", 64'(IF_RDATA),      64'd0);
    chk("rst_d_rdata",  64'(D_RDATA),       64'd0);

    fetch_0x10("fetch1");

    // Write then read back the same data word
    gnt_n = -1; rv_cnt = 0;
    D_REQ = 1; D_WE = 1; D_ADDR = 32'h0000_0100; D_WDATA = 32'hDEAD_BEEF;
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (D_GNT) begin gnt_n = n; D_REQ = 0; end
      if (D_RVALID) rv_cnt++;
    end
    D_REQ = 0;
    chk("wr_gnt_lat",   64'(gnt_n),  64'd1);
    chk("wr_no_rvalid", 64'(rv_cnt), 64'd0);
    rv_n = -1; rv_data = '0;
    D_REQ = 1; D_WE = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (D_GNT) D_REQ = 0;
      if (D_RVALID) begin rv_n = n; rv_data = D_RDATA; end
    end
    D_REQ = 0;
    chk("rd_rv_lat",  64'(rv_n),    64'd5);
    chk("rd_rv_data", 64'(rv_data), 64'hDEAD_BEEF);

    // Both requesters hold REQ continuously: four data grants, then one fetch grant
    IF_REQ = 1; IF_ADDR = 32'h0000_0010; D_REQ = 1; D_WE = 0; D_ADDR = 32'h0000_0100;
    glog.delete(); log_on = 1;
    repeat (62) tick();
    log_on = 0; IF_REQ = 0; D_REQ = 0;
    chk("starve_ngrants", 64'(glog.size() >= 10), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("starve_order", 64'((i < glog.size()) ? glog[i] : 99), 64'((i % 5 == 4) ? 1 : 0));
    end
    repeat (12) tick();

    // Reset while a fetch read is waiting on memory
    IF_REQ = 1; IF_ADDR = 32'h0000_0040;
    tick();
    chk("rstwait_gnt", 64'(IF_GNT), 64'd1);
    IF_REQ = 0;
    tick();
    RESET = 1;
    tick();
    RESET = 0;
    chk("rstwait_busy",     64'(BUSY),     64'd0);
    chk("rstwait_mem_cs",   64'(MEM_CS),   64'd0);
    chk("rstwait_if_rdata", 64'(IF_RDATA), 64'd0);
    chk("rstwait_d_rdata",  64'(D_RDATA),  64'd0);
    rv_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (IF_RVALID || D_RVALID) rv_cnt++;
    end
    chk("rstwait_no_rvalid", 64'(rv_cnt), 64'd0);
    fetch_0x10("fetch2");

    // Random traffic with occasional resets, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      RESET = ($urandom_range(0, 199) == 0);
      if (IF_REQ) begin
        if (IF_GNT) begin
          if ($urandom_range(0, 1) == 1) IF_REQ = 0;
          else IF_ADDR = rand_addr();
        end
      end else if ($urandom_range(0, 2) == 0) begin
        IF_REQ = 1; IF_ADDR = rand_addr();
      end
      if (D_REQ) begin
        if (D_GNT) begin
          if ($urandom_range(0, 1) == 1) D_REQ = 0;
          else begin D_ADDR = rand_addr(); D_WE = 1'($urandom_range(0, 1)); D_WDATA = $urandom; end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        D_REQ = 1; D_ADDR = rand_addr(); D_WE = 1'($urandom_range(0, 1)); D_WDATA = $urandom;
      end
    end
    RESET = 0; IF_REQ = 0; D_REQ = 0;
    repeat (15) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
